bus_cdc_arbiter: RTL and testbench
==================================

// Module: bus_cdc_arbiter
// PURPOSE
//  Round-robin arbiter sharing one bus_cdc_single CPU-side port among NUM_MASTERS requesters (CPU, debug, DMA).
//  Sequences each transaction: grant, issue, wait on halt, then return read data.
//  Inserts an idle-address gap cycle between transactions. bus_cdc_single only launches on an address change,
//  so the gap guarantees back-to-back accesses to the same address both launch.
//  Single clock (CPU domain); uses address_width/data_width from cpu_reg_package.
// PARAMETERS
//  NUM_MASTERS    2            number of requesters, 2..8
//  IDLE_ADDRESS   '1           address driven when no transaction is active; must lie outside every bus_cdc window
//  TIMEOUT_CYCLES 1024         max cycles spent in WAIT before the read is aborted; 0 disables the timeout
// PORTS
//  clk_i         in   1                          CPU-domain clock
//  reset_n_i     in   1                          asynchronous active-low reset
//  req_i         in   NUM_MASTERS                per-master request; held high until ack_o
//  we_i          in   NUM_MASTERS                per-master write enable (1=write, 0=read)
//  addr_i        in   NUM_MASTERS*address_width  per-master address, packed, master 0 in LSBs
//  wdata_i       in   NUM_MASTERS*data_width     per-master write data, packed
//  ack_o         out  NUM_MASTERS                one-cycle completion pulse to the granted master
//  err_o         out  NUM_MASTERS                one-cycle timeout pulse, coincident with ack_o
//  rdata_o       out  data_width                 read data; valid only while ack_o is high, else 0
//  bus_we_o      out  1                          to bus_cdc cpuside_we_i
//  bus_address_o out  address_width              to bus_cdc cpuside_address_i
//  bus_data_o    out  data_width                 to bus_cdc cpuside_data_i
//  bus_halt_i    in   1                          from bus_cdc cpuside_cpu_halt_o
//  bus_rdata_i   in   data_width                 from bus_cdc cpuside_module_data_o
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, ack_o=0, err_o=0, rdata_o=0,
//   bus_we_o=0, bus_address_o=IDLE_ADDRESS, bus_data_o=0, timeout counter=0.
//  FSM states: IDLE, ISSUE, WAIT, GAP.
//  IDLE:
//   - If any req_i is high and bus_halt_i==0, grant the first requester at or after rr_ptr (wrapping).
//   - Latch its we/addr/wdata; go to ISSUE.
//   - If bus_halt_i==1 (FIFO almost full), stay in IDLE; no grant.
//  ISSUE (exactly 1 cycle): drive the latched we/addr/data on bus_*_o.
//   - Write: pulse ack_o[g] this cycle; go to GAP.
//   - Read: go to WAIT.
//  WAIT:
//   - Hold bus_we_o=0, hold the address, and count cycles.
//   - First cycle in WAIT with bus_halt_i==0: rdata_o=bus_rdata_i and ack_o[g]=1, combinationally;
//     bus_rdata_i is itself a 1-cycle strobe. Go to GAP.
//   - Counter reaches TIMEOUT_CYCLES: ack_o[g]=1, err_o[g]=1, rdata_o=0; go to GAP.
//  GAP (1 cycle): bus_address_o=IDLE_ADDRESS, bus_we_o=0, bus_data_o=0; rr_ptr <= g+1 mod NUM_MASTERS; go to IDLE.
//  Latency:
//   - Write: ack 1 cycle after grant; 3 cycles minimum between grants.
//   - Read: ack in the first halt-free WAIT cycle.
//  Fairness: pointer advances only on completion. A master dropping req_i before ack is a protocol error;
//   the arbiter ignores it and completes the transaction anyway.
//  Simultaneous requests: only one master is granted; the others wait; at most NUM_MASTERS-1 transactions of waiting.
//  Outside an ack cycle: rdata_o=0 and ack_o=0, so read data can be OR-combined with other bus sources.
//  Reset mid-transaction: abandon immediately and return to the reset state; no ack is issued.
// TESTING
//  1. Single write, M0 addr=0x10 data=0xAB -> bus shows we=1,0x10,0xAB for 1 cycle; ack_o[0] same cycle;
//     next cycle bus_address_o=IDLE_ADDRESS.
//  2. Read, M1 addr=0x20; model halts 5 cycles then returns 0x5A -> ack_o[1]=1, rdata_o=0x5A in the halt-drop cycle;
//     err_o=0.
//  3. M0 and M1 both request continuously -> grants alternate 0,1,0,1. After reset, first grant goes to M0.
//  4. M0 reads 0x30 twice back-to-back -> two distinct address transitions via IDLE_ADDRESS; model sees 2 launches.
//  5. TIMEOUT_CYCLES=16, model never drops halt -> ack_o and err_o both pulse 16 cycles after WAIT entry;
//     rdata_o=0; next grant proceeds.
//  6. bus_halt_i held high in IDLE with req pending -> no grant. reset_n_i low during WAIT -> outputs return to
//     reset values immediately; no ack.

Source files
------------

// File: rtl/bus_cdc_arbiter.sv
// Round-robin arbiter that shares one bus_cdc CPU-side port among several requesters.
// Every transaction ends with an idle-address gap cycle so repeated accesses to one address still launch.
module bus_cdc_arbiter #(
    parameter int                       NUM_MASTERS    = 2,
    parameter int                       ADDRESS_WIDTH  = 16,
    parameter int                       DATA_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] IDLE_ADDRESS   = '1,
    parameter int                       TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [NUM_MASTERS-1:0]               req_i,
    input  logic [NUM_MASTERS-1:0]               we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_MASTERS-1:0]               ack_o,
    output logic [NUM_MASTERS-1:0]               err_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 bus_we_o,
    output logic [ADDRESS_WIDTH-1:0]             bus_address_o,
    output logic [DATA_WIDTH-1:0]                bus_data_o,
    input  logic                                 bus_halt_i,
    input  logic [DATA_WIDTH-1:0]                bus_rdata_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_BASE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         rr_ptr_q;
    logic [IDX_W-1:0]         grant_q;
    logic [IDX_W-1:0]         grant_d;
    logic                     any_req;
    logic [CNT_W-1:0]         cnt_q;
    logic                     bus_we_q;
    logic [ADDRESS_WIDTH-1:0] bus_address_q;
    logic [DATA_WIDTH-1:0]    bus_data_q;
    logic                     timeout_hit;
    logic                     write_done;
    logic                     read_done;
    logic                     timeout_done;
    logic [NUM_MASTERS-1:0]   grant_onehot;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        grant_d = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
            if (!any_req && req_i[idx]) begin
                any_req = 1'b1;
                grant_d = IDX_W'(idx);
            end
        end
    end

    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign write_done   = (state_q == S_ISSUE) && bus_we_q;
    assign read_done    = (state_q == S_WAIT) && !bus_halt_i;
    assign timeout_done = (state_q == S_WAIT) && bus_halt_i && timeout_hit;
    assign grant_onehot = ONE_HOT_BASE << grant_q;

    // Completion is combinational because bus_rdata_i is only a one-cycle strobe.
    assign ack_o   = (write_done || read_done || timeout_done) ? grant_onehot : '0;
    assign err_o   = timeout_done ? grant_onehot : '0;
    assign rdata_o = read_done ? bus_rdata_i : '0;

    assign bus_we_o      = bus_we_q;
    assign bus_address_o = bus_address_q;
    assign bus_data_o    = bus_data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            bus_we_q      <= 1'b0;
            bus_address_q <= IDLE_ADDRESS;
            bus_data_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A raised halt means the CDC FIFO is nearly full, so nothing new is started.
                    if (any_req && !bus_halt_i) begin
                        grant_q       <= grant_d;
                        bus_we_q      <= we_i[grant_d];
                        bus_address_q <= addr_i[int'(grant_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        bus_data_q    <= wdata_i[int'(grant_d)*DATA_WIDTH +: DATA_WIDTH];
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                    if (bus_we_q) begin
                        bus_address_q <= IDLE_ADDRESS;
                        bus_data_q    <= '0;
                        bus_we_q      <= 1'b0;
                        state_q       <= S_GAP;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus_halt_i || timeout_hit) begin
                        cnt_q         <= '0;
                        bus_address_q <= IDLE_ADDRESS;
                        bus_data_q    <= '0;
                        bus_we_q      <= 1'b0;
                        state_q       <= S_GAP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    rr_ptr_q <= (int'(grant_q) == NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cdc_arbiter.sv
// Self-checking bench for bus_cdc_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin model and a simple bus_cdc responder.
module tb_bus_cdc_arbiter;

    localparam int NM = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [AW-1:0] IDLE = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] req = '0;
    logic [NM-1:0] we = '0;
    logic [AW-1:0] addrM [NM] = '{default: '0};
    logic [DW-1:0] wdataM [NM] = '{default: '0};
    logic [NM*AW-1:0] addrBus;
    logic [NM*DW-1:0] wdataBus;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] rdata;
    logic          busWe;
    logic [AW-1:0] busAddr;
    logic [DW-1:0] busData;
    logic [DW-1:0] busRdata = '0;
    logic          modelHalt = 1'b0;
    logic          forceHalt = 1'b0;
    logic          busHalt;

    int checks = 0;
    int failures = 0;
    int launches = 0;
    int haltCnt = 0;
    int holdCycles = 3;
    bit neverDrop = 1'b0;
    logic [DW-1:0] nextResp = '0;
    logic [DW-1:0] respData = '0;
    logic [AW-1:0] prevAddr = IDLE;

    for (genvar i = 0; i < NM; i++) begin : g_pack
        assign addrBus[i*AW +: AW]  = addrM[i];
        assign wdataBus[i*DW +: DW] = wdataM[i];
    end
    assign busHalt = modelHalt | forceHalt;

    bus_cdc_arbiter #(
        .NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .IDLE_ADDRESS(IDLE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .req_i(req), .we_i(we),
        .addr_i(addrBus), .wdata_i(wdataBus), .ack_o(ack), .err_o(err),
        .rdata_o(rdata), .bus_we_o(busWe), .bus_address_o(busAddr),
        .bus_data_o(busData), .bus_halt_i(busHalt), .bus_rdata_i(busRdata)
    );

    always #5 clk = ~clk;

    // bus_cdc responder: a read launch holds halt for holdCycles WAIT cycles, then strobes data.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            modelHalt = 1'b0;
            haltCnt   = 0;
            busRdata  = '0;
            prevAddr  = IDLE;
        end else begin
            busRdata = '0;
            if (busAddr == IDLE) begin
                modelHalt = 1'b0;
                haltCnt   = 0;
            end else if (haltCnt > 0 && !neverDrop) begin
                haltCnt--;
                if (haltCnt == 0) begin
                    modelHalt = 1'b0;
                    busRdata  = respData;
                end
            end
            if (busAddr != prevAddr && busAddr != IDLE) begin
                launches++;
                if (!busWe) begin
                    modelHalt = 1'b1;
                    haltCnt   = holdCycles + 1;
                    respData  = nextResp;
                end
            end
            prevAddr = busAddr;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetDut();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic waitIssue(input logic [AW-1:0] a, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busAddr == a) ok = 1'b1;
        end
    endtask

    task automatic waitAck(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ack !== '0) begin failures++; $display("[TB] FAIL reset_ack: got %b want 000", ack); end
        checks++; if (err !== '0) begin failures++; $display("[TB] FAIL reset_err: got %b want 000", err); end
        checks++; if (rdata !== '0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (busWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b want 0", busWe); end
        checks++; if (busAddr !== IDLE) begin failures++; $display("[TB] FAIL reset_addr: got %h want %h", busAddr, IDLE); end
        checks++; if (busData !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h want 0", busData); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        int cyc;
        bit ok;
        we[0] = 1'b1; addrM[0] = 16'h0010; wdataM[0] = 32'hAB; req[0] = 1'b1;
        waitIssue(16'h0010, cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL wr_issue: got no launch want addr 0010"); end
        checks++; if (cyc != 2) begin failures++; $display("[TB] FAIL wr_latency: got %0d want 2", cyc); end
        checks++; if (busWe !== 1'b1) begin failures++; $display("[TB] FAIL wr_we: got %b want 1", busWe); end
        checks++; if (busData !== 32'hAB) begin failures++; $display("[TB] FAIL wr_data: got %h want ab", busData); end
        checks++; if (ack !== 3'b001) begin failures++; $display("[TB] FAIL wr_ack: got %b want 001", ack); end
        checks++; if (err !== 3'b000) begin failures++; $display("[TB] FAIL wr_err: got %b want 000", err); end
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        checks++; if (busAddr !== IDLE) begin failures++; $display("[TB] FAIL wr_gap_addr: got %h want %h", busAddr, IDLE); end
        checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL wr_gap_ack: got %b want 000", ack); end
    endtask

    task automatic test_single_read();
        int cyc;
        bit ok;
        @(posedge clk);
        #1;
        holdCycles = 5; nextResp = 32'h5A;
        we[1] = 1'b0; addrM[1] = 16'h0020; wdataM[1] = 32'h77; req[1] = 1'b1;
        waitIssue(16'h0020, cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rd_issue: got no launch want addr 0020"); end
        checks++; if (busWe !== 1'b0) begin failures++; $display("[TB] FAIL rd_we: got %b want 0", busWe); end
        waitAck(cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rd_ack_seen: got none want ack"); end
        checks++; if (cyc != 6) begin failures++; $display("[TB] FAIL rd_latency: got %0d want 6", cyc); end
        checks++; if (ack !== 3'b010) begin failures++; $display("[TB] FAIL rd_ack: got %b want 010", ack); end
        checks++; if (rdata !== 32'h5A) begin failures++; $display("[TB] FAIL rd_data: got %h want 5a", rdata); end
        checks++; if (err !== 3'b000) begin failures++; $display("[TB] FAIL rd_err: got %b want 000", err); end
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        checks++; if (rdata !== '0) begin failures++; $display("[TB] FAIL rd_after: got %h want 0", rdata); end
    endtask

    task automatic test_round_robin();
        int ptr;
        int n;
        int last;
        int g;
        logic [NM-1:0] expAck;
        resetDut();
        we = 3'b011;
        addrM[0] = 16'h0100; wdataM[0] = 32'h1;
        addrM[1] = 16'h0200; wdataM[1] = 32'h2;
        req = 3'b011;
        ptr = 0; n = 0; last = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (ack != '0) begin
                g = -1;
                for (int j = 0; j < NM; j++)
                    if (g < 0 && req[(ptr + j) % NM]) g = (ptr + j) % NM;
                expAck = NM'(1) << g;
                checks++; if (ack !== expAck) begin failures++; $display("[TB] FAIL rr_grant%0d: got %b want %b", n, ack, expAck); end
                if (n > 0) begin
                    checks++; if (cyc - last != 3) begin failures++; $display("[TB] FAIL rr_spacing%0d: got %0d want 3", n, cyc - last); end
                end
                last = cyc;
                ptr = (g + 1) % NM;
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("[TB] FAIL rr_count: got %0d want 4", n); end
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int l0;
        int n;
        int transitions;
        logic [AW-1:0] prevTb;
        l0 = launches; n = 0; transitions = 0; prevTb = busAddr;
        holdCycles = 2; nextResp = $urandom;
        we[0] = 1'b0; addrM[0] = 16'h0030; req[0] = 1'b1;
        for (int cyc = 0; cyc < 80 && n < 2; cyc++) begin
            @(negedge clk);
            if (busAddr == 16'h0030 && prevTb != 16'h0030) transitions++;
            if (ack != '0) begin
                checks++; if (ack !== 3'b001) begin failures++; $display("[TB] FAIL b2b_ack%0d: got %b want 001", n, ack); end
                checks++; if (rdata !== respData) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h want %h", n, rdata, respData); end
                n++;
                nextResp = $urandom;
            end
            prevTb = busAddr;
        end
        @(posedge clk);
        #1 req[0] = 1'b0;
        checks++; if (n != 2) begin failures++; $display("[TB] FAIL b2b_acks: got %0d want 2", n); end
        checks++; if (transitions != 2) begin failures++; $display("[TB] FAIL b2b_transitions: got %0d want 2", transitions); end
        checks++; if (launches - l0 != 2) begin failures++; $display("[TB] FAIL b2b_launches: got %0d want 2", launches - l0); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        neverDrop = 1'b1;
        we[2] = 1'b0; addrM[2] = 16'h0044; req[2] = 1'b1;
        waitIssue(16'h0044, cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL to_issue: got no launch want addr 0044"); end
        waitAck(cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL to_ack_seen: got none want ack"); end
        checks++; if (cyc != TO + 1) begin failures++; $display("[TB] FAIL to_latency: got %0d want %0d", cyc, TO + 1); end
        checks++; if (ack !== 3'b100) begin failures++; $display("[TB] FAIL to_ack: got %b want 100", ack); end
        checks++; if (err !== 3'b100) begin failures++; $display("[TB] FAIL to_err: got %b want 100", err); end
        checks++; if (rdata !== '0) begin failures++; $display("[TB] FAIL to_rdata: got %h want 0", rdata); end
        @(posedge clk);
        #1;
        req[2] = 1'b0; neverDrop = 1'b0;
        we[0] = 1'b1; addrM[0] = 16'h0050; wdataM[0] = 32'hC3; req[0] = 1'b1;
        waitAck(cyc, ok);
        checks++; if (ack !== 3'b001 || !ok) begin failures++; $display("[TB] FAIL to_next_ack: got %b want 001", ack); end
        checks++; if (err !== 3'b000) begin failures++; $display("[TB] FAIL to_next_err: got %b want 000", err); end
        @(posedge clk);
        #1 req[0] = 1'b0;
    endtask

    task automatic test_halt_and_reset();
        int cyc;
        bit ok;
        bit seen;
        forceHalt = 1'b1;
        we[1] = 1'b1; addrM[1] = 16'h0070; wdataM[1] = 32'h9; req[1] = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busAddr != IDLE || ack != '0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL halt_block: got grant want none"); end
        forceHalt = 1'b0;
        waitAck(cyc, ok);
        checks++; if (ack !== 3'b010 || !ok) begin failures++; $display("[TB] FAIL halt_release_ack: got %b want 010", ack); end
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        holdCycles = 20;
        we[0] = 1'b0; addrM[0] = 16'h0060; req[0] = 1'b1;
        waitIssue(16'h0060, cyc, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_issue: got no launch want addr 0060"); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busAddr !== IDLE) begin failures++; $display("[TB] FAIL rst_addr: got %h want %h", busAddr, IDLE); end
        checks++; if (busWe !== 1'b0 || busData !== '0) begin failures++; $display("[TB] FAIL rst_bus: got we=%b data=%h want 0", busWe, busData); end
        checks++; if (ack !== '0 || rdata !== '0) begin failures++; $display("[TB] FAIL rst_ack: got %b/%h want 0", ack, rdata); end
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL rst_no_ack: got ack want none"); end
    endtask

    task automatic test_random();
        int ptr;
        int g;
        int curG;
        int acks;
        bit inFlight;
        bit [NM-1:0] ackFlag;
        logic [NM-1:0] reqPrev;
        logic [NM-1:0] expAck;
        logic [DW-1:0] expData;
        logic [AW-1:0] prevTb;
        resetDut();
        ptr = 0; curG = 0; acks = 0; inFlight = 1'b0; ackFlag = '0; reqPrev = '0; prevTb = IDLE;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (busAddr != IDLE && prevTb == IDLE) begin
                g = -1;
                for (int j = 0; j < NM; j++)
                    if (g < 0 && reqPrev[(ptr + j) % NM]) g = (ptr + j) % NM;
                checks++;
                if (g < 0 || inFlight) begin
                    failures++; $display("[TB] FAIL rnd_spurious: got launch %h want none", busAddr);
                end else if (busAddr !== addrM[g] || busWe !== we[g] || busData !== wdataM[g]) begin
                    failures++;
                    $display("[TB] FAIL rnd_issue: got m? a=%h we=%b d=%h want m%0d a=%h we=%b d=%h",
                             busAddr, busWe, busData, g, addrM[g], we[g], wdataM[g]);
                end
                if (g >= 0) curG = g;
                inFlight = 1'b1;
            end
            if (ack != '0) begin
                expAck  = NM'(1) << curG;
                expData = we[curG] ? '0 : respData;
                checks++;
                if (!inFlight || ack !== expAck || err !== '0 || rdata !== expData) begin
                    failures++;
                    $display("[TB] FAIL rnd_ack: got ack=%b err=%b rd=%h want ack=%b err=000 rd=%h",
                             ack, err, rdata, expAck, expData);
                end
                ptr = (curG + 1) % NM;
                ackFlag[curG] = 1'b1;
                inFlight = 1'b0;
                acks++;
            end else begin
                checks++; if (rdata !== '0) begin failures++; $display("[TB] FAIL rnd_rdata_idle: got %h want 0", rdata); end
            end
            reqPrev = req;
            prevTb  = busAddr;
            @(posedge clk);
            #1;
            nextResp   = $urandom;
            holdCycles = int'($urandom_range(1, 8));
            for (int i = 0; i < NM; i++) begin
                if (ackFlag[i]) begin
                    req[i] = 1'b0;
                    ackFlag[i] = 1'b0;
                end else if (c < 420 && !req[i] && $urandom_range(0, 2) == 0) begin
                    we[i]     = 1'($urandom_range(0, 1));
                    addrM[i]  = AW'($urandom_range(0, 16'hFEFF));
                    wdataM[i] = $urandom;
                    req[i]    = 1'b1;
                end
            end
        end
        checks++; if (req !== '0) begin failures++; $display("[TB] FAIL rnd_drain: got pending %b want 000", req); end
        checks++; if (acks < 20) begin failures++; $display("[TB] FAIL rnd_progress: got %0d acks want >=20", acks); end
    endtask

    initial begin
        $display("[TB] starting bus_cdc_arbiter bench");
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_halt_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
